// File: rtl/cve2_md_issue_if.sv
// Request, engine and writeback signals for the M-extension issue/retire stage.
// The slave modport is the issue stage; master is its environment (ID/EX, engine, WB).
interface cve2_md_issue_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [2:0]  req_funct3_i;
  logic [31:0] req_op_a_i;
  logic [31:0] req_op_b_i;
  logic [4:0]  req_rd_i;

  logic        md_mult_en_o;
  logic        md_div_en_o;
  logic        md_mult_sel_o;
  logic        md_div_sel_o;
  logic [1:0]  md_operator_o;
  logic [1:0]  md_signed_mode_o;
  logic [31:0] md_op_a_o;
  logic [31:0] md_op_b_o;
  logic [67:0] md_imd_val_q_o;
  logic [67:0] md_imd_val_d_i;
  logic [1:0]  md_imd_val_we_i;
  logic        md_ready_id_o;
  logic [31:0] md_result_i;
  logic        md_valid_i;

  logic        wb_valid_o;
  logic        wb_ready_i;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;
  logic        busy_o;

  modport slave (
    input  req_valid_i, req_funct3_i, req_op_a_i, req_op_b_i, req_rd_i,
    output req_ready_o,
    output md_mult_en_o, md_div_en_o, md_mult_sel_o, md_div_sel_o,
    output md_operator_o, md_signed_mode_o, md_op_a_o, md_op_b_o,
    output md_imd_val_q_o, md_ready_id_o,
    input  md_imd_val_d_i, md_imd_val_we_i, md_result_i, md_valid_i,
    output wb_valid_o, wb_rd_o, wb_data_o, busy_o,
    input  wb_ready_i
  );

  modport master (
    output req_valid_i, req_funct3_i, req_op_a_i, req_op_b_i, req_rd_i,
    input  req_ready_o,
    input  md_mult_en_o, md_div_en_o, md_mult_sel_o, md_div_sel_o,
    input  md_operator_o, md_signed_mode_o, md_op_a_o, md_op_b_o,
    input  md_imd_val_q_o, md_ready_id_o,
    output md_imd_val_d_i, md_imd_val_we_i, md_result_i, md_valid_i,
    input  wb_valid_o, wb_rd_o, wb_data_o, busy_o,
    output wb_ready_i
  );
endinterface

// File: rtl/cve2_md_issue.sv
// RV32M issue/retire stage around the iterative mult/div engine: latches requests,
// owns the engine's intermediate registers and holds results in a writeback slot.
module cve2_md_issue #(
  parameter bit SKIP_RD0 = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  cve2_md_issue_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e      state_reg, state_next;
  logic        is_mult_reg;
  logic [1:0]  operator_reg;
  logic [1:0]  signed_mode_reg;
  logic [31:0] op_a_reg;
  logic [31:0] op_b_reg;
  logic [4:0]  rd_reg;

  logic        wb_valid_reg;
  logic [4:0]  wb_rd_reg;
  logic [31:0] wb_data_reg;

  logic [1:0]  dec_operator;
  logic [1:0]  dec_signed_mode;
  logic        accept;
  logic        wb_load;
  logic        md_ready_id;
  logic        active;

  always_comb begin
    dec_operator    = 2'd0;
    dec_signed_mode = 2'b00;
    case (bus.req_funct3_i)
      3'd0: begin dec_operator = 2'd0; dec_signed_mode = 2'b00; end
      3'd1: begin dec_operator = 2'd1; dec_signed_mode = 2'b11; end
      3'd2: begin dec_operator = 2'd1; dec_signed_mode = 2'b01; end
      3'd3: begin dec_operator = 2'd1; dec_signed_mode = 2'b00; end
      3'd4: begin dec_operator = 2'd2; dec_signed_mode = 2'b11; end
      3'd5: begin dec_operator = 2'd2; dec_signed_mode = 2'b00; end
      3'd6: begin dec_operator = 2'd3; dec_signed_mode = 2'b11; end
      default: begin dec_operator = 2'd3; dec_signed_mode = 2'b00; end
    endcase
  end

  always_comb begin
    state_next  = state_reg;
    accept      = 1'b0;
    wb_load     = 1'b0;
    md_ready_id = 1'b0;
    case (state_reg)
      IDLE: begin
        accept = bus.req_valid_i & ~flush_i;
        if (accept) state_next = BUSY;
      end
      BUSY: begin
        md_ready_id = ~wb_valid_reg | bus.wb_ready_i;
        // A result handed over in the flush cycle is already gone from the engine,
        // so drop it and return to IDLE rather than draining for a result that never comes.
        if (bus.md_valid_i && md_ready_id) begin
          wb_load    = ~flush_i & ~(SKIP_RD0 && (rd_reg == 5'd0));
          state_next = IDLE;
        end else if (flush_i) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        md_ready_id = 1'b1;
        if (bus.md_valid_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg       <= IDLE;
      is_mult_reg     <= 1'b0;
      operator_reg    <= 2'd0;
      signed_mode_reg <= 2'b00;
      op_a_reg        <= '0;
      op_b_reg        <= '0;
      rd_reg          <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        is_mult_reg     <= ~bus.req_funct3_i[2];
        operator_reg    <= dec_operator;
        signed_mode_reg <= dec_signed_mode;
        op_a_reg        <= bus.req_op_a_i;
        op_b_reg        <= bus.req_op_b_i;
        rd_reg          <= bus.req_rd_i;
      end
    end
  end

  // Slot clears on acceptance or flush unless a fresh result lands in the same cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wb_valid_reg <= 1'b0;
      wb_rd_reg    <= '0;
      wb_data_reg  <= '0;
    end else if (wb_load) begin
      wb_valid_reg <= 1'b1;
      wb_rd_reg    <= rd_reg;
      wb_data_reg  <= bus.md_result_i;
    end else if (bus.wb_ready_i || flush_i) begin
      wb_valid_reg <= 1'b0;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_imd
    logic [33:0] imd_reg;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        imd_reg <= '0;
      end else if (bus.md_imd_val_we_i[gi] && active) begin
        imd_reg <= bus.md_imd_val_d_i[34*gi +: 34];
      end
    end
    assign bus.md_imd_val_q_o[34*gi +: 34] = imd_reg;
  end

  assign active               = (state_reg != IDLE);
  assign bus.req_ready_o      = (state_reg == IDLE) & ~flush_i;
  assign bus.md_mult_en_o     = active & is_mult_reg;
  assign bus.md_mult_sel_o    = active & is_mult_reg;
  assign bus.md_div_en_o      = active & ~is_mult_reg;
  assign bus.md_div_sel_o     = active & ~is_mult_reg;
  assign bus.md_operator_o    = operator_reg;
  assign bus.md_signed_mode_o = signed_mode_reg;
  assign bus.md_op_a_o        = op_a_reg;
  assign bus.md_op_b_o        = op_b_reg;
  assign bus.md_ready_id_o    = md_ready_id;
  assign bus.wb_valid_o       = wb_valid_reg;
  assign bus.wb_rd_o          = wb_rd_reg;
  assign bus.wb_data_o        = wb_data_reg;
  assign bus.busy_o           = active;

endmodule

// File: tb/tb_cve2_md_issue.sv
// Bench for cve2_md_issue: a behavioural iterative engine plus vector table and corner sequences.
module tb_cve2_md_issue;

  localparam int ENG_LAT = 8;

  logic clk;
  logic rst_n;
  logic flush;

  cve2_md_issue_if bus ();

  cve2_md_issue #(.SKIP_RD0(1'b1)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .flush_i (flush),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [1:0]  exp_op;
    logic [1:0]  exp_sm;
    logic        exp_mult;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [31:0] eng_calc(input logic [1:0] op, input logic [1:0] sm,
                                           input logic [31:0] a, input logic [31:0] b);
    logic signed [33:0] sa, sb;
    logic signed [67:0] p;
    logic [31:0] q, r;
    sa = sm[0] ? $signed({{2{a[31]}}, a}) : $signed({2'b00, a});
    sb = sm[1] ? $signed({{2{b[31]}}, b}) : $signed({2'b00, b});
    p  = sa * sb;
    if (!op[1]) return op[0] ? p[63:32] : p[31:0];
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (sm == 2'b11) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = a;
        r = 32'd0;
      end else begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end
    end else begin
      q = a / b;
      r = a % b;
    end
    return op[0] ? r : q;
  endfunction

  // Engine model: counts while enabled, then presents a result until md_ready_id_o takes it.
  int eng_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eng_cnt        <= 0;
      bus.md_valid_i <= 1'b0;
      bus.md_result_i <= '0;
    end else if (!(bus.md_mult_en_o || bus.md_div_en_o)) begin
      eng_cnt        <= 0;
      bus.md_valid_i <= 1'b0;
    end else if (bus.md_valid_i) begin
      if (bus.md_ready_id_o) begin
        bus.md_valid_i <= 1'b0;
        eng_cnt        <= 0;
      end
    end else if (eng_cnt == ENG_LAT) begin
      bus.md_valid_i  <= 1'b1;
      bus.md_result_i <= eng_calc(bus.md_operator_o, bus.md_signed_mode_o,
                                  bus.md_op_a_o, bus.md_op_b_o);
    end else begin
      eng_cnt <= eng_cnt + 1;
    end
  end

  task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    @(negedge clk);
    bus.req_valid_i  = 1'b1;
    bus.req_funct3_i = f3;
    bus.req_op_a_i   = a;
    bus.req_op_b_i   = b;
    bus.req_rd_i     = rd;
    chk("req_ready", 68'(bus.req_ready_o), 68'd1);
    @(negedge clk);
    bus.req_valid_i = 1'b0;
  endtask

  task automatic wait_wb(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (bus.wb_valid_o) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic run_vec(input vec_t v);
    bit seen;
    bus.wb_ready_i = 1'b1;
    issue(v.f3, v.a, v.b, v.rd);
    chk({v.name, ".busy"},     68'(bus.busy_o), 68'd1);
    chk({v.name, ".mult_en"},  68'(bus.md_mult_en_o), 68'(v.exp_mult));
    chk({v.name, ".div_en"},   68'(bus.md_div_en_o), 68'(!v.exp_mult));
    chk({v.name, ".operator"}, 68'(bus.md_operator_o), 68'(v.exp_op));
    chk({v.name, ".sm"},       68'(bus.md_signed_mode_o), 68'(v.exp_sm));
    chk({v.name, ".op_a"},     68'(bus.md_op_a_o), 68'(v.a));
    chk({v.name, ".op_b"},     68'(bus.md_op_b_o), 68'(v.b));
    wait_wb(4 * ENG_LAT, seen);
    chk({v.name, ".wb_seen"},  68'(seen), 68'd1);
    chk({v.name, ".wb_data"},  68'(bus.wb_data_o), 68'(v.exp_data));
    chk({v.name, ".wb_rd"},    68'(bus.wb_rd_o), 68'(v.rd));
    chk({v.name, ".idle"},     68'(bus.busy_o), 68'd0);
    $display("txn %s a=%h b=%h rd=%0d -> data=%h rd=%0d", v.name, v.a, v.b, v.rd,
             bus.wb_data_o, bus.wb_rd_o);
    @(negedge clk);
    chk({v.name, ".wb_one_cycle"}, 68'(bus.wb_valid_o), 68'd0);
  endtask

  localparam logic [67:0] IMD_P1 = {34'h1_0F0F_0F0F, 34'h2_F0F0_F0F0};
  localparam logic [67:0] IMD_P2 = {34'h2_AAAA_5555, 34'h1_1234_5678};

  initial begin
    bit seen;
    bit stable_ok;
    bit no_wb;
    vec_t v;

    vecs[0] = '{"MUL",    3'd0, 32'd7,         32'd6,         5'd5,  2'd0, 2'b00, 1'b1, 32'h0000_002A};
    vecs[1] = '{"MULH",   3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1,  2'd1, 2'b11, 1'b1, 32'h4000_0000};
    vecs[2] = '{"MULHSU", 3'd2, 32'hFFFF_FFFF, 32'd2,         5'd2,  2'd1, 2'b01, 1'b1, 32'hFFFF_FFFF};
    vecs[3] = '{"MULHU",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  2'd1, 2'b00, 1'b1, 32'hFFFF_FFFE};
    vecs[4] = '{"DIV",    3'd4, 32'd5,         32'd0,         5'd4,  2'd2, 2'b11, 1'b0, 32'hFFFF_FFFF};
    vecs[5] = '{"DIVU",   3'd5, 32'd100,       32'd7,         5'd6,  2'd2, 2'b00, 1'b0, 32'h0000_000E};
    vecs[6] = '{"REM",    3'd6, 32'hFFFF_FFF9, 32'd2,         5'd12, 2'd3, 2'b11, 1'b0, 32'hFFFF_FFFF};
    vecs[7] = '{"REMU",   3'd7, 32'd100,       32'd7,         5'd31, 2'd3, 2'b00, 1'b0, 32'h0000_0002};

    rst_n               = 1'b0;
    flush               = 1'b0;
    bus.req_valid_i     = 1'b0;
    bus.req_funct3_i    = '0;
    bus.req_op_a_i      = '0;
    bus.req_op_b_i      = '0;
    bus.req_rd_i        = '0;
    bus.md_imd_val_d_i  = '0;
    bus.md_imd_val_we_i = '0;
    bus.wb_ready_i      = 1'b1;

    #2;
    chk("rst.req_ready", 68'(bus.req_ready_o), 68'd1);
    chk("rst.busy",      68'(bus.busy_o), 68'd0);
    chk("rst.wb_valid",  68'(bus.wb_valid_o), 68'd0);
    chk("rst.en",        68'({bus.md_mult_en_o, bus.md_div_en_o}), 68'd0);
    chk("rst.ready_id",  68'(bus.md_ready_id_o), 68'd0);
    chk("rst.imd",       bus.md_imd_val_q_o, 68'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Intermediate registers must ignore writes while idle.
    bus.md_imd_val_we_i = 2'b11;
    bus.md_imd_val_d_i  = IMD_P1;
    repeat (3) @(negedge clk);
    chk("imd_idle_hold", bus.md_imd_val_q_o, 68'd0);
    bus.md_imd_val_we_i = 2'b00;

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Back-to-back with a stalled writeback slot.
    bus.wb_ready_i = 1'b0;
    issue(3'd5, 32'd100, 32'd7, 5'd7);
    wait_wb(4 * ENG_LAT, seen);
    chk("b2b.first_seen", 68'(seen), 68'd1);
    issue(3'd5, 32'd200, 32'd7, 5'd8);
    stable_ok = 1'b1;
    for (int i = 0; i < 4 * ENG_LAT && !bus.md_valid_i; i++) begin
      if (!bus.wb_valid_o || bus.wb_data_o !== 32'hE || bus.wb_rd_o !== 5'd7) stable_ok = 1'b0;
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    if (!bus.wb_valid_o || bus.wb_data_o !== 32'hE || bus.wb_rd_o !== 5'd7) stable_ok = 1'b0;
    chk("b2b.slot_stable", 68'(stable_ok), 68'd1);
    chk("b2b.eng_waiting", 68'(bus.md_valid_i), 68'd1);
    chk("b2b.ready_id_low", 68'(bus.md_ready_id_o), 68'd0);
    chk("b2b.busy", 68'(bus.busy_o), 68'd1);
    bus.wb_ready_i = 1'b1;
    @(negedge clk);
    chk("b2b.second_valid", 68'(bus.wb_valid_o), 68'd1);
    chk("b2b.second_data",  68'(bus.wb_data_o), 68'h1C);
    chk("b2b.second_rd",    68'(bus.wb_rd_o), 68'd8);
    $display("txn B2B first=0000000e rd=7, second=%h rd=%0d", bus.wb_data_o, bus.wb_rd_o);
    @(negedge clk);
    chk("b2b.drained", 68'(bus.wb_valid_o), 68'd0);

    // Flush five cycles into a DIV, drain, then check the next MUL.
    bus.md_imd_val_we_i = 2'b11;
    bus.md_imd_val_d_i  = IMD_P2;
    issue(3'd4, 32'd100, 32'd7, 5'd10);
    @(negedge clk);
    chk("flush.imd_busy_write", bus.md_imd_val_q_o, IMD_P2);
    repeat (3) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    bus.md_imd_val_we_i = 2'b00;
    chk("flush.drain_busy",     68'(bus.busy_o), 68'd1);
    chk("flush.drain_en",       68'(bus.md_div_en_o), 68'd1);
    chk("flush.drain_ready_id", 68'(bus.md_ready_id_o), 68'd1);
    chk("flush.drain_no_req",   68'(bus.req_ready_o), 68'd0);
    no_wb = 1'b1;
    seen  = 1'b0;
    for (int i = 0; i < 4 * ENG_LAT; i++) begin
      if (bus.wb_valid_o) no_wb = 1'b0;
      if (!bus.busy_o) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("flush.back_idle", 68'(seen), 68'd1);
    chk("flush.no_wb", 68'(no_wb), 68'd1);
    chk("flush.imd_kept", bus.md_imd_val_q_o, IMD_P2);
    $display("txn FLUSH DIV 100/7 rd=10 discarded");
    v = '{"MUL_after_flush", 3'd0, 32'd3, 32'd3, 5'd9, 2'd0, 2'b00, 1'b1, 32'd9};
    run_vec(v);

    // rd==0 result is dropped.
    issue(3'd0, 32'd5, 32'd5, 5'd0);
    no_wb = 1'b1;
    seen  = 1'b0;
    for (int i = 0; i < 4 * ENG_LAT; i++) begin
      if (bus.wb_valid_o) no_wb = 1'b0;
      if (!bus.busy_o) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    if (bus.wb_valid_o) no_wb = 1'b0;
    chk("rd0.back_idle", 68'(seen), 68'd1);
    chk("rd0.no_wb", 68'(no_wb), 68'd1);
    $display("txn MUL rd=0 dropped");

    // Reset in the middle of a DIV.
    bus.md_imd_val_we_i = 2'b11;
    bus.md_imd_val_d_i  = IMD_P1;
    issue(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd11);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst.req_ready", 68'(bus.req_ready_o), 68'd1);
    chk("midrst.busy",      68'(bus.busy_o), 68'd0);
    chk("midrst.en",        68'({bus.md_mult_en_o, bus.md_div_en_o, bus.md_mult_sel_o, bus.md_div_sel_o}), 68'd0);
    chk("midrst.operator",  68'({bus.md_operator_o, bus.md_signed_mode_o}), 68'd0);
    chk("midrst.op_a",      68'(bus.md_op_a_o), 68'd0);
    chk("midrst.imd",       bus.md_imd_val_q_o, 68'd0);
    chk("midrst.wb_valid",  68'(bus.wb_valid_o), 68'd0);
    $display("txn RESET mid-DIV");
    @(negedge clk);
    rst_n = 1'b1;
    bus.md_imd_val_we_i = 2'b00;
    run_vec(vecs[7]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
